// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4_pkg: shared types and frame constants for the TDM 4-channel
// demultiplexer and its slot decoder.
// Configuration macro: TDM_DEMUX4_PARITY_EN (adds a fifth even-parity slot).
package tdm_demux4_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int unsigned NUM_CH = 4;

`ifdef TDM_DEMUX4_PARITY_EN
  localparam int unsigned FRAME_LEN = 5;
  localparam int unsigned S_W       = 3;
`else
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned S_W       = 2;
`endif

  // Slot index of the final beat of a frame (data slot 3, or the parity slot)
  localparam logic [S_W-1:0] LAST_SLOT = S_W'(FRAME_LEN - 1);
  // Highest slot index that carries channel data
  localparam logic [S_W-1:0] LAST_CH   = S_W'(NUM_CH - 1);

endpackage

// File: rtl/tdm_demux4_dec2to4_en.sv
// dec2to4_en: 2-to-4 one-hot decoder with enable.
// Ports:
//   en  - enable; all outputs low when 0
//   a   - 2-bit select
//   y   - one-hot output, y[k]=1 when en and a==k
module dec2to4_en (
  input  logic       en,
  input  logic [1:0] a,
  output logic [0:3] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[a] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receives a time-division-multiplexed serial stream and
// redistributes each 4-slot frame into a registered parallel word.
// Configuration macro: TDM_DEMUX4_PARITY_EN (5-slot frame, slot 4 carries
// the XOR of channels 0..3; mismatching frames are dropped).
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   En         - block enable; when low all state holds
//   sync       - frame marker, with din_valid marks slot 0
//   din        - slot payload
//   din_valid  - din valid this cycle
//   S          - slot index the next valid beat is written to
//   Y          - one-hot decode of S while collecting (0 in parity slot)
//   W          - committed frame, channel k at bits k*DATA_W +: DATA_W
//   frame_done - one-cycle pulse when W updates
//   parity_err - one-cycle pulse on parity mismatch (0 without the feature)
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     En,
  input  logic                     sync,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  output logic [S_W-1:0]           S,
  output logic [0:NUM_CH-1]        Y,
  output logic [0:NUM_CH*DATA_W-1] W,
  output logic                     frame_done,
  output logic                     parity_err
);

  state_e                     state_q;
  logic [S_W-1:0]             s_q;
  logic [DATA_W-1:0]          shadow_q [NUM_CH];
  logic [0:NUM_CH*DATA_W-1]   w_q;
  logic                       done_q;
  logic                       perr_q;

  // Frame as it would be committed on this beat
  logic [0:NUM_CH*DATA_W-1]   w_d;

  logic                       beat;
  assign beat = En && din_valid;

`ifdef TDM_DEMUX4_PARITY_EN
  // Even parity over the buffered channels
  logic [DATA_W-1:0] par_d;

  always_comb begin
    par_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      par_d = par_d ^ shadow_q[k];
    end
  end

  always_comb begin
    w_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_d[k*DATA_W +: DATA_W] = shadow_q[k];
    end
  end
`else
  // Slot 3 is taken straight from din so the commit needs no extra cycle
  always_comb begin
    w_d = '0;
    for (int unsigned k = 0; k < NUM_CH - 1; k++) begin
      w_d[k*DATA_W +: DATA_W] = shadow_q[k];
    end
    w_d[(NUM_CH-1)*DATA_W +: DATA_W] = din;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      s_q     <= '0;
      w_q     <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      perr_q <= 1'b0;
      if (beat) begin
        if (sync) begin
          // Frame start or resync: any partial frame is abandoned
          shadow_q[0] <= din;
          s_q         <= S_W'(1);
          state_q     <= COLLECT;
        end else if (state_q == COLLECT) begin
          if (s_q == LAST_SLOT) begin
            s_q <= '0;
`ifdef TDM_DEMUX4_PARITY_EN
            if (din == par_d) begin
              w_q    <= w_d;
              done_q <= 1'b1;
            end else begin
              perr_q <= 1'b1;
            end
`else
            shadow_q[NUM_CH-1] <= din;
            w_q                <= w_d;
            done_q             <= 1'b1;
`endif
          end else begin
            shadow_q[s_q[1:0]] <= din;
            s_q                <= s_q + S_W'(1);
          end
        end
      end
    end
  end

  dec2to4_en u_dec (
    .en (state_q == COLLECT && s_q <= LAST_CH),
    .a  (s_q[1:0]),
    .y  (Y)
  );

  assign S          = s_q;
  assign W          = w_q;
  assign frame_done = done_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;
  import tdm_demux4_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             En;
  logic             sync;
  logic [0:0]       din;
  logic             din_valid;
  logic [S_W-1:0]   S;
  logic [0:3]       Y;
  logic [0:3]       W;
  logic             frame_done;
  logic             parity_err;

  tdm_demux4 #(.DATA_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .En         (En),
    .sync       (sync),
    .din        (din),
    .din_valid  (din_valid),
    .S          (S),
    .Y          (Y),
    .W          (W),
    .frame_done (frame_done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic        perr;
    logic [0:3]  w;
    int unsigned at;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [0:3] oh(input int unsigned s);
    logic [0:3] r;
    r = '0;
    if (s < 4) r[s] = 1'b1;
    return r;
  endfunction

  // Monitor: every frame_done / parity_err pulse must match the next expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (frame_done !== 1'b0 || parity_err !== 1'b0)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: frame_done=%b parity_err=%b W=%b cycle %0d",
                 frame_done, parity_err, W, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ev_parity_err", parity_err, e.perr);
        chk("ev_frame_done", frame_done, !e.perr);
        chk("ev_W", W, e.w);
        chk("ev_cycle", cyc, e.at);
      end
    end
  end

  task automatic expect_ev(input logic [0:3] w, input logic perr);
    q.push_back('{perr: perr, w: w, at: cyc + 1});
  endtask

  task automatic beat(input logic s, input logic d);
    En        = 1'b1;
    din_valid = 1'b1;
    sync      = s;
    din       = d;
    @(negedge clk);
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic chk_sy(input string tag, input int unsigned s, input logic [0:3] y);
    chk({tag, "_S"}, S, s);
    chk({tag, "_Y"}, Y, y);
  endtask

  // Full frame starting with sync, S/Y checked after each beat
  task automatic send_frame(input string tag, input logic [0:3] f);
    for (int unsigned k = 0; k < 4; k++) begin
`ifndef TDM_DEMUX4_PARITY_EN
      if (k == 3) expect_ev(f, 1'b0);
`endif
      beat(k == 0, f[k]);
      chk_sy(tag, (k + 1) % FRAME_LEN, oh((k + 1) % FRAME_LEN));
    end
`ifdef TDM_DEMUX4_PARITY_EN
    expect_ev(f, 1'b0);
    beat(1'b0, ^f);
    chk_sy(tag, 0, 4'b1000);
`endif
  endtask

  initial begin
    rst_n = 1'b0; En = 1'b0; sync = 1'b0; din = '0; din_valid = 1'b0;
    #12;
    chk_sy("reset", 0, 4'b0000);
    chk("reset_W", W, 4'b0000);
    chk("reset_done", frame_done, 1'b0);
    chk("reset_perr", parity_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // HUNT drops unsynced beats
    beat(1'b0, 1'b1);
    chk_sy("hunt1", 0, 4'b0000);
    beat(1'b0, 1'b0);
    chk_sy("hunt2", 0, 4'b0000);

    // Test 1: single frame 1011
    send_frame("t1", 4'b1011);
    @(negedge clk);
    chk("t1_W_hold", W, 4'b1011);

    // Test 2: back-to-back frames
    send_frame("t2a", 4'b1011);
    send_frame("t2b", 4'b0110);
    chk("t2_W", W, 4'b0110);

    // Test 3: resync at S=2 discards partial frame
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    chk_sy("t3_pre", 2, 4'b0010);
    beat(1'b1, 1'b1);
    chk_sy("t3_resync", 1, 4'b0100);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
`ifdef TDM_DEMUX4_PARITY_EN
    beat(1'b0, 1'b1);
    expect_ev(4'b1001, 1'b0);
    beat(1'b0, 1'b0);
`else
    expect_ev(4'b1001, 1'b0);
    beat(1'b0, 1'b1);
`endif
    chk("t3_W", W, 4'b1001);

    // Test 4: En low mid-frame freezes everything
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      En        = 1'b0;
      din_valid = 1'b1;
      din       = 1'(i);
      sync      = (i == 2);
      @(negedge clk);
      chk_sy("t4_hold", 2, 4'b0010);
      chk("t4_W_hold", W, 4'b1001);
    end
    din_valid = 1'b0;
    sync      = 1'b0;
    beat(1'b0, 1'b1);
`ifdef TDM_DEMUX4_PARITY_EN
    beat(1'b0, 1'b1);
    expect_ev(4'b1011, 1'b0);
    beat(1'b0, 1'b1);
`else
    expect_ev(4'b1011, 1'b0);
    beat(1'b0, 1'b1);
`endif
    chk("t4_W", W, 4'b1011);

`ifdef TDM_DEMUX4_PARITY_EN
    // Test 6: parity good then bad
    send_frame("t6a", 4'b1101);
    chk("t6_W_good", W, 4'b1101);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    chk_sy("t6_par_slot", 4, 4'b0000);
    expect_ev(4'b1101, 1'b1);
    beat(1'b0, 1'b0);
    chk_sy("t6_after", 0, 4'b1000);
    chk("t6_W_held", W, 4'b1101);
`endif

    // Test 5: async reset at S=3 discards frame, back to HUNT
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    chk_sy("t5_pre", 3, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_sy("t5_rst", 0, 4'b0000);
    chk("t5_rst_W", W, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 1'b1);
    chk_sy("t5_hunt1", 0, 4'b0000);
    beat(1'b0, 1'b1);
    chk_sy("t5_hunt2", 0, 4'b0000);
    chk("t5_W", W, 4'b0000);
    send_frame("t5_new", 4'b0110);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
